div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40, meaning the WAIT-state cycle limit used only when the watchdog is compiled in.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  input  1  execute stage holds a div instruction.
REQ-005 SHALL have port issue_a / issue_b  input  32 each  dividend / divisor, two's complement.
REQ-006 SHALL have port issue_rd  input  5  destination register.
REQ-007 SHALL have port flush  input  1  pipeline flush; cancels any in-flight div.
REQ-008 SHALL have port stall  output  1  freezes stages at and before execute.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port div_start  output  1  one-cycle start pulse to the divider.
REQ-011 SHALL have port div_a / div_b  output  32 each  latched operands to the divider.
REQ-012 SHALL have port div_out  input  32  divider quotient.
REQ-013 SHALL have port div_exp / div_ready  input  1 each  divider exception and done strobe.
REQ-014 SHALL have port wb_valid / wb_rd / wb_data  output  1/5/32  one-cycle writeback request to the regfile.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-016 In IDLE, issue_valid=1 and flush=0 SHALL latch issue_a, issue_b, issue_rd, drive stall=1 combinationally in that cycle, and go to START.
REQ-017 In START: div_start=1 for exactly one cycle, div_a/div_b = latched operands; div_ready ignored; next state WAIT.
REQ-018 In WAIT: stall=1; on div_ready=1 SHALL capture div_out and div_exp, then go to DONE.
REQ-019 In DONE: stall=0, wb_valid=1 for exactly one cycle; next state IDLE; issue_valid ignored (same instruction still present).
REQ-020 Latency: accept at cycle T, div_start at T+1, div_ready at T+1+N, wb_valid at T+2+N.
REQ-021 An exception is raised when captured div_exp=1 or latched divisor==0; the result is then wb_rd=5'd30, wb_data=32'd5; otherwise wb_rd=latched rd, wb_data=captured div_out.
REQ-022 wb_rd=0 SHALL still assert wb_valid; discarding is the regfile's job.
REQ-023 flush=1 in START or WAIT SHALL go to IDLE next cycle: no wb_valid, stall=0 from that cycle; the divider's later div_ready is ignored.
REQ-024 flush=1 in DONE SHALL not suppress that cycle's wb_valid.
REQ-025 div_a/div_b SHALL hold the latched values from START until the next accept.
REQ-026 div_start SHALL never assert outside START.

Reset
REQ-027 reset=1 SHALL force IDLE from any state, including mid-WAIT, on the next edge.
REQ-028 Reset values: stall, busy, div_start, wb_valid = 0; div_a, div_b, wb_data = 0; wb_rd = 0.
REQ-029 Reset SHALL take priority over flush and issue_valid in the same cycle.

Configuration
REQ-030 With macro DIV_ISSUE_CTRL_TIMEOUT_EN defined, a WAIT-cycle counter SHALL force DONE with an exception writeback (r30, 32'd5) once TIMEOUT_CYCLES WAIT cycles pass without div_ready.
REQ-031 Without DIV_ISSUE_CTRL_TIMEOUT_EN, WAIT SHALL persist until div_ready, flush or reset; the port list is identical in both builds.

Structure
REQ-032 Shared package multdiv_pkg SHALL hold the state encoding, RSTATUS_REG=5'd30, DIV_EXC_CODE=32'd5 and the default TIMEOUT_CYCLES.
REQ-033 The watchdog SHALL be a sub-module div_timeout_ctr (count enable, clear, terminal flag), instantiated only under the macro.

Verification
REQ-034 A=100, B=7, rd=3 -> one div_start pulse; after div_ready, wb_valid with wb_rd=3, wb_data=14; stall high from accept until DONE.
REQ-035 A=-100, B=7, rd=4 -> wb_data=32'hFFFFFFF2 (-14), wb_rd=4.
REQ-036 B=0, rd=5 -> wb_rd=30, wb_data=5, no write to r5.
REQ-037 flush two cycles into WAIT -> IDLE next cycle, no wb_valid, stall=0; a later div_ready is ignored; a new issue restarts cleanly.
REQ-038 reset asserted mid-WAIT -> all outputs 0 next cycle; the following issue completes normally.
REQ-039 (macro on) div_ready held low -> after 40 WAIT cycles, wb_valid with r30/5 and stall released.

Source files
------------

// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the divide issue controller:
//   - div_state_t   : FSM state encoding (IDLE, START, WAIT, DONE)
//   - RSTATUS_REG   : register that receives the exception code (r30)
//   - DIV_EXC_CODE  : value written to RSTATUS_REG on a divide exception
//   - DEFAULT_TIMEOUT_CYCLES : default WAIT-state limit for the optional
//                              watchdog (DIV_ISSUE_CTRL_TIMEOUT_EN)
//   - wb_t / make_wb : writeback request record and its selection helper
// -----------------------------------------------------------------------------
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } div_state_t;

  localparam logic [4:0]  RSTATUS_REG            = 5'd30;
  localparam logic [31:0] DIV_EXC_CODE           = 32'd5;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 40;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  // An exception redirects the writeback to the status register with a
  // fixed code; the original destination is dropped entirely.
  function automatic wb_t make_wb(input logic        exc,
                                  input logic [4:0]  rd,
                                  input logic [31:0] quotient);
    wb_t w;
    if (exc) begin
      w.rd   = RSTATUS_REG;
      w.data = DIV_EXC_CODE;
    end else begin
      w.rd   = rd;
      w.data = quotient;
    end
    return w;
  endfunction

endpackage

// File: rtl/div_timeout_ctr.sv
// -----------------------------------------------------------------------------
// div_timeout_ctr
// WAIT-state watchdog counter for div_issue_ctrl. Counts enabled cycles and
// raises term_o during the LIMIT-th consecutive enabled cycle, so the owner
// can leave WAIT on that same edge.
// Only instantiated when DIV_ISSUE_CTRL_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   en_i    : count this cycle (controller is in WAIT with no div_ready)
//   clr_i   : clear count (controller not in WAIT)
//   term_o  : terminal flag, high in the LIMIT-th counted cycle
// -----------------------------------------------------------------------------
module div_timeout_ctr
  import multdiv_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic term_o
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          at_last;

  assign at_last = (count_q == LAST);
  assign term_o  = en_i && at_last;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !at_last) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Issue/writeback controller that sits between the execute stage and an
// iterative divider. Accepts a div from execute, stalls the front of the
// pipeline, launches the divider with a one-cycle start pulse, waits for the
// done strobe and presents a one-cycle writeback request to the regfile.
// Divide-by-zero or a divider exception redirects the writeback to r30 with
// exception code 5.
//
// Optional build macro: DIV_ISSUE_CTRL_TIMEOUT_EN
//   When defined, a watchdog (div_timeout_ctr) forces an exception writeback
//   after TIMEOUT_CYCLES WAIT cycles without div_ready. The port list is the
//   same in both builds.
//
// Handshake: issue_valid is a level held by execute while stalled; the
// controller accepts it in IDLE only. div_start is a single-cycle pulse;
// div_ready is a single-cycle done strobe honoured only in WAIT. wb_valid is a
// single-cycle request with no back-pressure; the regfile must take it.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   issue_valid           : execute holds a div instruction
//   issue_a, issue_b      : dividend / divisor (two's complement)
//   issue_rd              : destination register
//   flush                 : cancel any in-flight div
//   stall                 : freeze stages at and before execute
//   busy                  : controller not in IDLE
//   div_start             : one-cycle start pulse to the divider
//   div_a, div_b          : latched operands to the divider
//   div_out               : divider quotient
//   div_exp, div_ready    : divider exception flag and done strobe
//   wb_valid/wb_rd/wb_data: one-cycle writeback request
//   dbg_state             : current FSM state (debug observation only)
// -----------------------------------------------------------------------------
module div_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_out,
  input  logic        div_exp,
  input  logic        div_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  dbg_state
);

  div_state_t  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic accept;
  logic capture;
  logic force_exc;
  logic timeout_hit;
  wb_t  wb_next;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef DIV_ISSUE_CTRL_TIMEOUT_EN
  logic tmo_en;
  logic tmo_clr;

  // Flush leaves WAIT on its own, so it must not also count as a wait cycle.
  assign tmo_en  = (state_q == ST_WAIT) && !div_ready && !flush;
  assign tmo_clr = (state_q != ST_WAIT);

  div_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (tmo_en),
    .clr_i  (tmo_clr),
    .term_o (timeout_hit)
  );
`else
  // Without the watchdog WAIT only ends on div_ready, flush or reset. The
  // limit is a non-negative count, so this term is constant low.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    force_exc = 1'b0;
    stall     = 1'b0;
    div_start = 1'b0;
    wb_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Stall must rise in the accept cycle itself so execute holds the
        // instruction steady while its operands are latched.
        if (issue_valid && !flush) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        div_start = 1'b1;
        stall     = !flush;
        state_d   = flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        stall = !flush;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_ready) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          capture   = 1'b1;
          force_exc = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // Writeback is already committed here; a flush cannot retract it.
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset wins over any accept, capture or stall request in the same cycle.
    if (reset) begin
      state_d   = ST_IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
      force_exc = 1'b0;
      stall     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_next   = make_wb(force_exc || div_exp || (b_q == 32'd0), rd_q, div_out);

    if (accept) begin
      a_d  = issue_a;
      b_d  = issue_b;
      rd_d = issue_rd;
    end
    if (capture) begin
      wb_rd_d   = wb_next.rd;
      wb_data_d = wb_next.data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
// Directed bench for div_issue_ctrl. The driver plays both the execute stage
// and the divider, pushing the hand-computed writeback for each issue into
// exp_q; a monitor pops and compares on every wb_valid.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_out;
  logic        div_exp;
  logic        div_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  div_issue_ctrl #(
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .div_start   (div_start),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_out     (div_out),
    .div_exp     (div_exp),
    .div_ready   (div_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback request must match the oldest expectation.
  always @(negedge clock) begin
    logic [36:0] e;
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk1("wb_unexpected", wb_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_all_zero(input string tag);
    chk1({tag, "_stall"}, stall, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_div_start"}, div_start, 1'b0);
    chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk({tag, "_div_a"}, div_a, 32'd0);
    chk({tag, "_div_b"}, div_b, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
  endtask

  // One complete div: accept, START, n WAIT cycles (ready in the n-th),
  // DONE, back to IDLE. The divider is first poked with a bogus div_ready in
  // START, which must be ignored.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int n,
                         input logic [31:0] q, input logic dexp,
                         input logic [4:0] e_rd, input logic [31:0] e_data,
                         input logic flush_in_done);
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_a = a; issue_b = b; issue_rd = rd;
    @(negedge clock);
    chk1("accept_stall", stall, 1'b1);
    chk1("accept_busy", busy, 1'b0);
    chk1("accept_no_start", div_start, 1'b0);
    exp_q.push_back({e_rd, e_data});

    @(posedge clock); #1;
    div_ready = 1'b1; div_out = 32'hDEAD_BEEF;
    @(negedge clock);
    chk1("start_pulse", div_start, 1'b1);
    chk("start_div_a", div_a, a);
    chk("start_div_b", div_b, b);
    chk1("start_stall", stall, 1'b1);

    @(posedge clock); #1;
    div_ready = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(negedge clock);
      chk1("wait_stall", stall, 1'b1);
      chk1("wait_no_start", div_start, 1'b0);
      chk1("wait_no_wb", wb_valid, 1'b0);
      @(posedge clock); #1;
    end
    div_ready = 1'b1; div_out = q; div_exp = dexp;
    @(negedge clock);
    chk1("ready_stall", stall, 1'b1);

    @(posedge clock); #1;
    div_ready = 1'b0; div_exp = 1'b0; div_out = 32'd0; flush = flush_in_done;
    @(negedge clock);
    chk1("done_wb_valid", wb_valid, 1'b1);
    chk1("done_stall", stall, 1'b0);
    chk1("done_busy", busy, 1'b1);
    chk("done_div_a_held", div_a, a);

    @(posedge clock); #1;
    flush = 1'b0; issue_valid = 1'b0;
    @(negedge clock);
    chk1("after_busy", busy, 1'b0);
    chk1("after_wb_valid", wb_valid, 1'b0);
    chk("after_div_b_held", div_b, b);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_a = '0; issue_b = '0; issue_rd = '0;
    flush = 1'b0; div_out = '0; div_exp = 1'b0; div_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    // a, b, rd, ready-in-wait-cycle, quotient, div_exp, exp rd, exp data, flush in DONE
    run_div(32'd100,        32'd7,  5'd3, 3, 32'd14,        1'b0, 5'd3,  32'd14,        1'b0);
    run_div(32'hFFFF_FF9C,  32'd7,  5'd4, 1, 32'hFFFF_FFF2, 1'b0, 5'd4,  32'hFFFF_FFF2, 1'b0);
    run_div(32'd50,         32'd0,  5'd5, 2, 32'hFFFF_FFFF, 1'b0, 5'd30, 32'd5,         1'b0);
    run_div(32'd9,          32'd3,  5'd7, 1, 32'd3,         1'b1, 5'd30, 32'd5,         1'b0);
    run_div(32'd20,         32'd4,  5'd0, 4, 32'd5,         1'b0, 5'd0,  32'd5,         1'b0);
    run_div(32'd1000,       32'd10, 5'd9, 2, 32'd100,       1'b0, 5'd9,  32'd100,       1'b1);

    // Flush two cycles into WAIT, then a stray div_ready, then a clean issue.
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_a = 32'd77; issue_b = 32'd7; issue_rd = 5'd8;
    repeat (3) begin @(posedge clock); #1; end
    flush = 1'b1; issue_valid = 1'b0;
    @(negedge clock);
    chk1("flush_stall", stall, 1'b0);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_wb_valid", wb_valid, 1'b0);
    div_ready = 1'b1; div_out = 32'd11;
    @(posedge clock); #1;
    div_ready = 1'b0; div_out = 32'd0;
    @(negedge clock);
    chk1("stray_ready_busy", busy, 1'b0);
    run_div(32'd77, 32'd7, 5'd8, 2, 32'd11, 1'b0, 5'd8, 32'd11, 1'b0);

    // Reset in WAIT with issue_valid also high: reset wins.
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_a = 32'd30; issue_b = 32'd3; issue_rd = 5'd6;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(negedge clock);
    chk1("reset_cycle_stall", stall, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0; issue_valid = 1'b0;
    @(negedge clock);
    check_all_zero("mid_wait_reset");
    run_div(32'd30, 32'd3, 5'd6, 1, 32'd10, 1'b0, 5'd6, 32'd10, 1'b0);

`ifdef DIV_ISSUE_CTRL_TIMEOUT_EN
    // Watchdog: div_ready never arrives; expect DONE after 40 WAIT cycles.
    begin
      int waits;
      waits = 0;
      @(posedge clock); #1;
      issue_valid = 1'b1; issue_a = 32'd64; issue_b = 32'd8; issue_rd = 5'd12;
      exp_q.push_back({5'd30, 32'd5});
      @(posedge clock); #1;   // START
      @(posedge clock); #1;   // first WAIT cycle
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        if (wb_valid === 1'b1) break;
        waits++;
      end
      chk("timeout_wait_cycles", waits, 32'd40);
      chk1("timeout_done_stall", stall, 1'b0);
      @(posedge clock); #1;
      issue_valid = 1'b0;
      @(negedge clock);
      chk1("timeout_idle_busy", busy, 1'b0);
    end
`else
    // No watchdog: WAIT persists well past 40 cycles until a flush.
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_a = 32'd64; issue_b = 32'd8; issue_rd = 5'd12;
    repeat (62) begin @(posedge clock); #1; end
    @(negedge clock);
    chk1("long_wait_busy", busy, 1'b1);
    chk1("long_wait_stall", stall, 1'b1);
    @(posedge clock); #1;
    flush = 1'b1; issue_valid = 1'b0;
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk1("long_wait_flush_busy", busy, 1'b0);
`endif

    repeat (3) @(posedge clock);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
